// File: rtl/rr_burst_arbiter4_pkg.sv
// Shared types, constants and the round-robin pick function for the
// 4-requester burst arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int          N_REQ   = 4;
    localparam logic [3:0]  PTR_RST = 4'b1000;

    // Winner is the first set req bit scanning circularly from just after ptr.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [N_REQ-1:0] ptr);
        logic [N_REQ-1:0] win;
        logic [1:0]       base;
        logic [1:0]       idx;
        logic             found;
        win   = 4'b0000;
        base  = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ptr[i]) begin
                base = i[1:0];
            end
        end
        for (int k = 1; k <= N_REQ; k++) begin
            idx = base + k[1:0];
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_burst_arbiter4_if.sv
// Request/data bundle between four requesters, the arbiter and the
// downstream valid/ready channel.
interface rr_burst_arbiter4_if #(
    parameter int K = 8
);
    import rr_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] in_last;
    logic [K-1:0]     a0;
    logic [K-1:0]     a1;
    logic [K-1:0]     a2;
    logic [K-1:0]     a3;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] ack;
    logic             out_valid;
    logic [K-1:0]     out_data;
    logic             out_last;
    logic             out_ready;

    modport master (
        input  req, in_last, a0, a1, a2, a3, out_ready,
        output gnt, ack, out_valid, out_data, out_last
    );

    modport slave (
        output req, in_last, a0, a1, a2, a3, out_ready,
        input  gnt, ack, out_valid, out_data, out_last
    );

endinterface

// File: rtl/rr_burst_arbiter4_onehot_mux4.sv
// One-hot AND-OR select of four K-bit words; all-zero select yields zero.
module onehot_mux4 #(
    parameter int K = 8
) (
    input  logic [K-1:0] a0,
    input  logic [K-1:0] a1,
    input  logic [K-1:0] a2,
    input  logic [K-1:0] a3,
    input  logic [3:0]   s,
    output logic [K-1:0] b
);

    assign b = ({K{s[0]}} & a0) | ({K{s[1]}} & a1)
             | ({K{s[2]}} & a2) | ({K{s[3]}} & a3);

endmodule

// File: rtl/rr_burst_arbiter4.sv
// Round-robin arbiter granting one of four requesters a burst on a shared
// valid/ready output channel, with one idle cycle between grants.
module rr_burst_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int K         = 8,
    parameter int MAX_BURST = 4,
    parameter int CW        = 8
) (
    input  logic              clk,
    input  logic              rst,
    rr_burst_arbiter4_if.master bus
);

    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    state_t            state_r;
    state_t            state_s;
    logic [N_REQ-1:0]  gnt_r;
    logic [N_REQ-1:0]  gnt_s;
    logic [N_REQ-1:0]  ptr_r;
    logic [N_REQ-1:0]  ptr_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_s;
    logic              held_s;
    logic              valid_s;
    logic              last_s;
    logic              beat_s;
    logic [K-1:0]      data_s;

    // A beat presented during reset is never accepted, so valid and ack are masked.
    assign held_s  = |(bus.req & gnt_r);
    assign valid_s = held_s & ~rst;
    assign last_s  = (state_r == XFER) & ((|(bus.in_last & gnt_r)) | (cnt_r == LAST_CNT));
    assign beat_s  = valid_s & bus.out_ready;

    onehot_mux4 #(.K(K)) u_data_mux (
        .a0 (bus.a0),
        .a1 (bus.a1),
        .a2 (bus.a2),
        .a3 (bus.a3),
        .s  (gnt_r),
        .b  (data_s)
    );

    assign bus.gnt       = gnt_r;
    assign bus.ack       = beat_s ? gnt_r : 4'b0000;
    assign bus.out_valid = valid_s;
    assign bus.out_data  = data_s;
    assign bus.out_last  = last_s;

    // State, grant, priority pointer and burst counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            ptr_r   <= PTR_RST;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state: arbitrate in IDLE; in XFER count beats, close or abort the burst.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    gnt_s   = rr_pick(bus.req, ptr_r);
                    ptr_s   = gnt_s;
                    cnt_s   = '0;
                    state_s = XFER;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                if (!held_s) begin
                    // Requester withdrew: release without ack; ptr keeps it as last winner.
                    gnt_s   = 4'b0000;
                    cnt_s   = '0;
                    state_s = IDLE;
                end else if (beat_s && last_s) begin
                    gnt_s   = 4'b0000;
                    cnt_s   = '0;
                    state_s = IDLE;
                end else if (beat_s) begin
                    cnt_s   = cnt_r + CW'(1);
                end else begin
                    cnt_s   = cnt_r;
                end
            end
            default: begin
                gnt_s   = 4'b0000;
                cnt_s   = '0;
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_burst_arbiter4.sv
// Directed bench for rr_burst_arbiter4: a vector table for the round-robin
// and in_last bursts, then hand sequences for cutoff, stall, abort and reset.
module tb_rr_burst_arbiter4;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   onehot_err;

    rr_burst_arbiter4_if #(.K(8)) bus ();

    rr_burst_arbiter4 #(.K(8), .MAX_BURST(4), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!$onehot0(bus.gnt)) onehot_err <= onehot_err + 1;
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] in_last;
        logic       rdy;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       valid;
        logic [7:0] data;
        logic       last;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance past the edge.
    task automatic cyc(input string nm, input logic [3:0] r, input logic [3:0] il,
                       input logic rdy, input logic [3:0] eg, input logic [3:0] ea,
                       input logic ev, input logic [7:0] ed, input logic el);
        bus.req       = r;
        bus.in_last   = il;
        bus.out_ready = rdy;
        #2;
        chk({nm, ".gnt"},   32'(bus.gnt),       32'(eg));
        chk({nm, ".ack"},   32'(bus.ack),       32'(ea));
        chk({nm, ".valid"}, 32'(bus.out_valid), 32'(ev));
        chk({nm, ".data"},  32'(bus.out_data),  32'(ed));
        chk({nm, ".last"},  32'(bus.out_last),  32'(el));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        onehot_err = 0;

        tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 8'h10, 1'b1};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h2, 4'h2, 1'b1, 8'h11, 1'b1};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'h4, 4'h4, 1'b1, 8'h12, 1'b1};
        tbl[6]  = '{4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'h8, 4'h8, 1'b1, 8'h13, 1'b1};
        tbl[8]  = '{4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 8'h10, 1'b1};
        tbl[10] = '{4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{4'h4, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[12] = '{4'h4, 4'h0, 1'b1, 4'h4, 4'h4, 1'b1, 8'h12, 1'b0};
        tbl[13] = '{4'h4, 4'h0, 1'b1, 4'h4, 4'h4, 1'b1, 8'h12, 1'b0};
        tbl[14] = '{4'h4, 4'h4, 1'b1, 4'h4, 4'h4, 1'b1, 8'h12, 1'b1};
        tbl[15] = '{4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};

        rst           = 1'b1;
        bus.req       = 4'b0000;
        bus.in_last   = 4'b0000;
        bus.out_ready = 1'b1;
        bus.a0        = 8'h10;
        bus.a1        = 8'h11;
        bus.a2        = 8'h12;
        bus.a3        = 8'h13;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin single-beat grants, then a 3-beat in_last burst.
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("tbl%0d", i), tbl[i].req, tbl[i].in_last, tbl[i].rdy,
                tbl[i].gnt, tbl[i].ack, tbl[i].valid, tbl[i].data, tbl[i].last);
        end

        // MAX_BURST cutoff on requester 1, regrant after one idle cycle.
        cyc("cut_idle", 4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        cyc("cut_b1",   4'h2, 4'h0, 1'b1, 4'h2, 4'h2, 1'b1, 8'h11, 1'b0);
        cyc("cut_b2",   4'h2, 4'h0, 1'b1, 4'h2, 4'h2, 1'b1, 8'h11, 1'b0);
        cyc("cut_b3",   4'h2, 4'h0, 1'b1, 4'h2, 4'h2, 1'b1, 8'h11, 1'b0);
        cyc("cut_b4",   4'h2, 4'h0, 1'b1, 4'h2, 4'h2, 1'b1, 8'h11, 1'b1);
        cyc("cut_bub",  4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        cyc("cut_regnt",4'h2, 4'h0, 1'b1, 4'h2, 4'h2, 1'b1, 8'h11, 1'b0);
        cyc("cut_drop", 4'h0, 4'h0, 1'b1, 4'h2, 4'h0, 1'b0, 8'h11, 1'b0);
        cyc("cut_end",  4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);

        // Stall on requester 3: data held, ack only when ready, cnt advances by 2.
        bus.a3 = 8'hA5;
        cyc("stl_idle", 4'h8, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        cyc("stl_r1",   4'h8, 4'h0, 1'b1, 4'h8, 4'h8, 1'b1, 8'hA5, 1'b0);
        cyc("stl_r0a",  4'h8, 4'h0, 1'b0, 4'h8, 4'h0, 1'b1, 8'hA5, 1'b0);
        cyc("stl_r0b",  4'h8, 4'h0, 1'b0, 4'h8, 4'h0, 1'b1, 8'hA5, 1'b0);
        cyc("stl_r1b",  4'h8, 4'h0, 1'b1, 4'h8, 4'h8, 1'b1, 8'hA5, 1'b0);
        cyc("stl_b3",   4'h8, 4'h0, 1'b1, 4'h8, 4'h8, 1'b1, 8'hA5, 1'b0);
        cyc("stl_b4",   4'h8, 4'h0, 1'b1, 4'h8, 4'h8, 1'b1, 8'hA5, 1'b1);
        cyc("stl_end",  4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);

        // Abort: requester 0 withdraws mid-burst while requester 2 waits.
        cyc("abt_idle", 4'h5, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        cyc("abt_b1",   4'h5, 4'h0, 1'b1, 4'h1, 4'h1, 1'b1, 8'h10, 1'b0);
        cyc("abt_drop", 4'h4, 4'h0, 1'b1, 4'h1, 4'h0, 1'b0, 8'h10, 1'b0);
        cyc("abt_rel",  4'h4, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        cyc("abt_g2",   4'h4, 4'h4, 1'b1, 4'h4, 4'h4, 1'b1, 8'h12, 1'b1);
        cyc("abt_end",  4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);

        // Reset mid-burst on requester 1 restores the priority pointer.
        cyc("rst_idle", 4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        cyc("rst_b1",   4'h2, 4'h0, 1'b1, 4'h2, 4'h2, 1'b1, 8'h11, 1'b0);
        rst = 1'b1;
        #2;
        chk("rst_cyc.gnt", 32'(bus.gnt), 32'(4'h2));
        chk("rst_cyc.ack", 32'(bus.ack), 32'(4'h0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rst_after", 4'hA, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        cyc("rst_g1",    4'hA, 4'h0, 1'b1, 4'h2, 4'h2, 1'b1, 8'h11, 1'b0);

        chk("onehot0_gnt", 32'(onehot_err), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
